// File: rtl/pea_cmd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pea_cmd_pkg: opcodes, field positions, error words and FSM encoding.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pea_cmd_pkg;

  localparam logic [2:0] c_op_nop = 3'd0;
  localparam logic [2:0] c_op_evp = 3'd1;
  localparam logic [2:0] c_op_evb = 3'd2;
  localparam logic [2:0] c_op_clr = 3'd3;

  localparam int c_opc_lsb = 0;
  localparam int c_opc_msb = 2;
  localparam int c_a_lsb   = 3;
  localparam int c_a_msb   = 5;
  localparam int c_b_lsb   = 6;
  localparam int c_b_msb   = 10;

  localparam logic [15:0] c_err_prefix  = 16'hEEEE;
  localparam logic [7:0]  c_err_none    = 8'h00;
  localparam logic [7:0]  c_err_illegal = 8'h01;
  localparam logic [7:0]  c_err_b_range = 8'h02;
  localparam logic [7:0]  c_err_timeout = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LATCH  = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_WR_RES = 3'd5,
    ST_WR_STS = 3'd6,
    ST_WR_ERR = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP = 3'd0,
    CLS_EVP = 3'd1,
    CLS_EVB = 3'd2,
    CLS_CLR = 3'd3,
    CLS_ERR = 3'd4
  } cls_t;

  function automatic logic [31:0] err_word(input logic [7:0] code, input logic [2:0] opcode);
    return {c_err_prefix, code, 5'b0, opcode};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pea_cmd_scheduler_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pea_cmd_scheduler_if: FIFO, engine and status signals of the scheduler.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pea_cmd_scheduler_if #(
  parameter int CW = 11
) ();
  logic [CW-1:0] cmd_count;
  logic [31:0]   cmd_data;
  logic          cmd_rd_en;
  logic [CW-1:0] out_free;
  logic          out_wr_en;
  logic [31:0]   out_data;
  logic          eng_start_evp;
  logic          eng_start_evb;
  logic [2:0]    eng_A;
  logic [4:0]    eng_b;
  logic          eng_done_evp;
  logic          eng_done_evb;
  logic [31:0]   eng_result;
  logic [31:0]   eng_status;
  logic          busy;
  logic [15:0]   op_count;
  logic [7:0]    err_count;

  modport master (
    input  cmd_count, cmd_data, out_free, eng_done_evp, eng_done_evb, eng_result, eng_status,
    output cmd_rd_en, out_wr_en, out_data, eng_start_evp, eng_start_evb, eng_A, eng_b,
           busy, op_count, err_count
  );

  modport slave (
    output cmd_count, cmd_data, out_free, eng_done_evp, eng_done_evb, eng_result, eng_status,
    input  cmd_rd_en, out_wr_en, out_data, eng_start_evp, eng_start_evb, eng_A, eng_b,
           busy, op_count, err_count
  );
endinterface
`default_nettype wire

// File: rtl/pea_cmd_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pea_cmd_decode: instruction word -> op class, fields, legality, code.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pea_cmd_decode
  import pea_cmd_pkg::*;
#(
  parameter int MAX_B = 20
) (
  input  logic [c_b_msb:0] instr,
  output cls_t             cls,
  output logic [2:0]       opcode,
  output logic [2:0]       a,
  output logic [4:0]       b,
  output logic             legal,
  output logic [7:0]       err_code
);
  localparam logic [4:0] c_max_b = 5'(MAX_B);

  assign opcode = instr[c_opc_msb:c_opc_lsb];
  assign a      = instr[c_a_msb:c_a_lsb];
  assign b      = instr[c_b_msb:c_b_lsb];
  assign legal  = (cls != CLS_ERR);

  always_comb begin
    cls      = CLS_ERR;
    err_code = c_err_illegal;
    case (opcode)
      c_op_nop: begin cls = CLS_NOP; err_code = c_err_none; end
      c_op_evp: begin cls = CLS_EVP; err_code = c_err_none; end
      c_op_clr: begin cls = CLS_CLR; err_code = c_err_none; end
      c_op_evb: begin
        if (b > c_max_b) begin
          cls      = CLS_ERR;
          err_code = c_err_b_range;
        end else begin
          cls      = CLS_EVB;
          err_code = c_err_none;
        end
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/pea_cmd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pea_cmd_scheduler: fetches instructions, runs the EVP/EVB engine and     |
// | pushes result/status (or an error word) to the output FIFO.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pea_cmd_scheduler
  import pea_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 1024,
  parameter int MAX_B      = 20,
  parameter int TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                rst,
  pea_cmd_scheduler_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  state_t        r_state, w_next;
  cls_t          w_cls;
  logic [2:0]    w_opcode, w_a;
  logic [4:0]    w_b;
  logic          w_legal;
  logic [7:0]    w_err_code;

  logic [2:0]    r_opcode;
  logic [7:0]    r_err_code;
  logic          r_is_evb;
  logic [2:0]    r_eng_a;
  logic [4:0]    r_eng_b;
  logic [31:0]   r_result, r_status;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_op_count;
  logic [7:0]    r_err_count;

  logic          w_can_fetch, w_done, w_tmo_hit;
  logic          w_cmd_rd_en, w_start_evp, w_start_evb, w_out_wr_en;
  logic [31:0]   w_out_data;

  pea_cmd_decode #(.MAX_B(MAX_B)) u_decode (
    .instr    (bus.cmd_data[c_b_msb:0]),
    .cls      (w_cls),
    .opcode   (w_opcode),
    .a        (w_a),
    .b        (w_b),
    .legal    (w_legal),
    .err_code (w_err_code)
  );

  // Two output slots are reserved up front so no operation stalls mid-flight.
  assign w_can_fetch = (bus.cmd_count != '0) && (bus.out_free[CW-1:1] != '0);
  assign w_done      = r_is_evb ? bus.eng_done_evb : bus.eng_done_evp;
  assign w_tmo_hit   = (r_tmo == c_tmo_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_rd_en = 1'b0;
    w_start_evp = 1'b0;
    w_start_evb = 1'b0;
    w_out_wr_en = 1'b0;
    w_out_data  = '0;
    case (r_state)
      ST_IDLE:  if (w_can_fetch) w_next = ST_FETCH;
      ST_FETCH: begin w_cmd_rd_en = 1'b1; w_next = ST_LATCH; end
      ST_LATCH: begin
        if (!w_legal)                                   w_next = ST_WR_ERR;
        else if (w_cls == CLS_NOP || w_cls == CLS_CLR)  w_next = ST_IDLE;
        else                                            w_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_start_evp = !r_is_evb;
        w_start_evb = r_is_evb;
        w_next      = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done)         w_next = ST_WR_RES;
        else if (w_tmo_hit) w_next = ST_WR_ERR;
      end
      ST_WR_RES: begin w_out_wr_en = 1'b1; w_out_data = r_result; w_next = ST_WR_STS; end
      ST_WR_STS: begin w_out_wr_en = 1'b1; w_out_data = r_status; w_next = ST_IDLE; end
      ST_WR_ERR: begin
        w_out_wr_en = 1'b1;
        w_out_data  = err_word(r_err_code, r_opcode);
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opcode    <= '0;
      r_err_code  <= '0;
      r_is_evb    <= 1'b0;
      r_eng_a     <= '0;
      r_eng_b     <= '0;
      r_result    <= '0;
      r_status    <= '0;
      r_tmo       <= '0;
      r_op_count  <= '0;
      r_err_count <= '0;
    end else begin
      case (r_state)
        ST_LATCH: begin
          r_opcode   <= w_opcode;
          r_err_code <= w_err_code;
          r_is_evb   <= (w_cls == CLS_EVB);
          r_eng_a    <= w_a;
          r_eng_b    <= w_b;
          if (w_cls == CLS_CLR) begin
            r_op_count  <= '0;
            r_err_count <= '0;
          end else if (w_cls == CLS_NOP) begin
            r_op_count <= r_op_count + 16'd1;
          end
        end
        ST_ISSUE: r_tmo <= '0;
        ST_WAIT: begin
          if (w_done) begin
            r_result <= bus.eng_result;
            r_status <= bus.eng_status;
          end else if (w_tmo_hit) begin
            r_err_code <= c_err_timeout;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        ST_WR_STS: r_op_count <= r_op_count + 16'd1;
        ST_WR_ERR: if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        default: ;
      endcase
    end
  end

  assign bus.cmd_rd_en     = w_cmd_rd_en;
  assign bus.out_wr_en     = w_out_wr_en;
  assign bus.out_data      = w_out_data;
  assign bus.eng_start_evp = w_start_evp;
  assign bus.eng_start_evb = w_start_evb;
  assign bus.eng_A         = r_eng_a;
  assign bus.eng_b         = r_eng_b;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.op_count      = r_op_count;
  assign bus.err_count     = r_err_count;
endmodule
`default_nettype wire

// File: tb/tb_pea_cmd_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pea_cmd_scheduler: vector table + scoreboard bench for the scheduler. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pea_cmd_scheduler;
  localparam int CW      = 11;
  localparam int TIMEOUT = 4096;
  localparam int NV      = 10;

  typedef struct {
    logic [31:0] instr;
    int          kind;    // 0 no engine run, 1 EVP, 2 EVB
    int          delay;
    bit          stray;
    logic [31:0] res;
    logic [31:0] sts;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [2:0]  exp_a;
    logic [4:0]  exp_b;
    logic [15:0] exp_op;
    logic [7:0]  exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   n_evp = 0, n_evb = 0, n_rd = 0, n_wr = 0;
  logic [31:0] cmd_q[$];
  logic [31:0] sb_q[$];
  vec_t vecs[NV];

  pea_cmd_scheduler_if #(.CW(CW)) bus ();

  pea_cmd_scheduler #(.FIFO_DEPTH(1024), .MAX_B(20), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Command FIFO model: read data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (bus.cmd_rd_en) begin
      if (cmd_q.size() != 0) bus.cmd_data <= cmd_q.pop_front();
      else begin
        bus.cmd_data <= 32'hDEAD_BEEF;
        errors++;
        $display("FAIL cmd_underflow: got pop with empty FIFO, expected none");
      end
    end
    bus.cmd_count <= CW'(cmd_q.size());
  end

  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (bus.eng_start_evp) n_evp++;
    if (bus.eng_start_evb) n_evb++;
    if (bus.cmd_rd_en)     n_rd++;
    if (bus.out_wr_en) begin
      n_wr++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got %h expected no write", bus.out_data);
      end else begin
        exp_w = sb_q.pop_front();
        if (bus.out_data !== exp_w) begin
          errors++;
          $display("FAIL out_word: got %h expected %h", bus.out_data, exp_w);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (bus.eng_start_evp || bus.eng_start_evb) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!bus.busy && sb_q.size() == 0 && cmd_q.size() == 0 && bus.cmd_count == '0) ok = 1'b1;
    end
  endtask

  task automatic drive_engine(input int kind, input int delay, input bit stray,
                              input logic [31:0] res, input logic [31:0] sts);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      bus.eng_result = 32'hBAD0_0000 | 32'(i);
      bus.eng_status = ~bus.eng_result;
      if (kind == 1) bus.eng_done_evb = stray && (i == delay / 2);
      else           bus.eng_done_evp = stray && (i == delay / 2);
    end
    @(posedge clk); #1;
    bus.eng_done_evp = (kind == 1);
    bus.eng_done_evb = (kind == 2);
    bus.eng_result   = res;
    bus.eng_status   = sts;
    @(posedge clk); #1;
    bus.eng_done_evp = 1'b0;
    bus.eng_done_evb = 1'b0;
    bus.eng_result   = 32'hBAD0_FFFF;
    bus.eng_status   = 32'hBAD1_FFFF;
    @(negedge clk);
    chk("res_push_latency_wr", 32'(bus.out_wr_en), 32'd1);
    chk("res_push_latency_data", bus.out_data, res);
  endtask

  function automatic vec_t mk(logic [31:0] instr, int kind, int delay, bit stray,
                              logic [31:0] res, logic [31:0] sts, int nw,
                              logic [31:0] w0, logic [31:0] w1, logic [2:0] a,
                              logic [4:0] b, logic [15:0] op, logic [7:0] err);
    vec_t v;
    v.instr = instr; v.kind = kind; v.delay = delay; v.stray = stray;
    v.res = res; v.sts = sts; v.nw = nw; v.w0 = w0; v.w1 = w1;
    v.exp_a = a; v.exp_b = b; v.exp_op = op; v.exp_err = err;
    return v;
  endfunction

  initial begin
    bit          ok, got;
    int          evp0, evb0, rd0, wr0, cyc;
    vec_t        v;
    logic [31:0] clr_cmds[4] = '{32'h06, 32'h00, 32'h00, 32'h03};
    logic [15:0] clr_op[4]   = '{16'd0, 16'd1, 16'd2, 16'd0};
    logic [7:0]  clr_err[4]  = '{8'd1, 8'd1, 8'd1, 8'd0};

    rst = 1'b1;
    bus.out_free     = CW'(8);
    bus.eng_done_evp = 1'b0;
    bus.eng_done_evb = 1'b0;
    bus.eng_result   = '0;
    bus.eng_status   = '0;

    //            instr           kind dly str res            sts        nw w0              w1         A  b   op  err
    vecs[0] = mk(32'h0000_0009,   1,   2,  0, 32'h0000_1234, 32'h0,     2, 32'h0000_1234, 32'h0,     1, 0,  1, 0);
    vecs[1] = mk(32'h0000_0152,   2,   40, 1, 32'h0000_ABCD, 32'h0,     2, 32'h0000_ABCD, 32'h0,     2, 5,  2, 0);
    vecs[2] = mk(32'h0000_0006,   0,   0,  0, 32'h0,         32'h0,     1, 32'hEEEE_0106, 32'h0,     0, 0,  2, 1);
    vecs[3] = mk(32'h0000_0642,   0,   0,  0, 32'h0,         32'h0,     1, 32'hEEEE_0202, 32'h0,     0, 0,  2, 2);
    vecs[4] = mk(32'h0000_0039,   1,   3,  1, 32'hDEAD_BEEF, 32'h55,    2, 32'hDEAD_BEEF, 32'h55,    7, 0,  3, 2);
    vecs[5] = mk(32'h0000_0502,   2,   0,  0, 32'h1111_1111, 32'h2,     2, 32'h1111_1111, 32'h2,     0, 20, 4, 2);
    vecs[6] = mk(32'h0000_0542,   0,   0,  0, 32'h0,         32'h0,     1, 32'hEEEE_0202, 32'h0,     0, 0,  4, 3);
    vecs[7] = mk(32'h0000_0000,   0,   0,  0, 32'h0,         32'h0,     0, 32'h0,         32'h0,     0, 0,  5, 3);
    vecs[8] = mk(32'hFFFF_F807,   0,   0,  0, 32'h0,         32'h0,     1, 32'hEEEE_0107, 32'h0,     0, 0,  5, 4);
    vecs[9] = mk(32'hABC0_0011,   1,   1,  0, 32'h0000_0005, 32'h7,     2, 32'h0000_0005, 32'h7,     2, 0,  6, 4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_op_count", 32'(bus.op_count), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_eng_fields", 32'({bus.eng_A, bus.eng_b}), 32'd0);
    chk("rst_strobes", 32'({bus.cmd_rd_en, bus.out_wr_en, bus.eng_start_evp, bus.eng_start_evb}), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      v    = vecs[k];
      evp0 = n_evp; evb0 = n_evb; rd0 = n_rd;
      if (v.nw > 0) sb_q.push_back(v.w0);
      if (v.nw > 1) sb_q.push_back(v.w1);
      cmd_q.push_back(v.instr);
      if (v.kind != 0) begin
        wait_start(ok);
        chk($sformatf("v%0d_start_seen", k), 32'(ok), 32'd1);
        chk($sformatf("v%0d_eng_A", k), 32'(bus.eng_A), 32'(v.exp_a));
        chk($sformatf("v%0d_eng_b", k), 32'(bus.eng_b), 32'(v.exp_b));
        drive_engine(v.kind, v.delay, v.stray, v.res, v.sts);
      end
      wait_idle(200, ok);
      chk($sformatf("v%0d_idle", k), 32'(ok), 32'd1);
      chk($sformatf("v%0d_op_count", k), 32'(bus.op_count), 32'(v.exp_op));
      chk($sformatf("v%0d_err_count", k), 32'(bus.err_count), 32'(v.exp_err));
      chk($sformatf("v%0d_evp_starts", k), 32'(n_evp - evp0), 32'(v.kind == 1));
      chk($sformatf("v%0d_evb_starts", k), 32'(n_evb - evb0), 32'(v.kind == 2));
      chk($sformatf("v%0d_pops", k), 32'(n_rd - rd0), 32'd1);
    end

    // Timeout: engine never answers; error word lands TIMEOUT+1 cycles after start.
    wr0 = n_wr;
    sb_q.push_back(32'hEEEE_0301);
    cmd_q.push_back(32'h0000_0001);
    wait_start(ok);
    chk("tmo_start_seen", 32'(ok), 32'd1);
    got = 1'b0; cyc = 0;
    for (int i = 1; i <= TIMEOUT + 50 && !got; i++) begin
      @(negedge clk);
      if (bus.out_wr_en) begin got = 1'b1; cyc = i; end
    end
    chk("tmo_latency", 32'(cyc), 32'(TIMEOUT + 1));
    wait_idle(50, ok);
    chk("tmo_idle", 32'(ok), 32'd1);
    chk("tmo_err_count", 32'(bus.err_count), 32'd5);
    chk("tmo_op_count", 32'(bus.op_count), 32'd6);
    @(posedge clk); #1;
    bus.eng_done_evp = 1'b1;
    bus.eng_result   = 32'h0000_0777;
    @(posedge clk); #1;
    bus.eng_done_evp = 1'b0;
    repeat (10) @(negedge clk);
    chk("late_done_writes", 32'(n_wr - wr0), 32'd1);
    chk("late_done_busy", 32'(bus.busy), 32'd0);

    // Backpressure: one free slot blocks fetching entirely.
    bus.out_free = CW'(1);
    rd0 = n_rd;
    repeat (3) cmd_q.push_back(32'h0000_0000);
    repeat (10) @(negedge clk);
    chk("bp_no_fetch", 32'(n_rd - rd0), 32'd0);
    chk("bp_idle", 32'(bus.busy), 32'd0);
    bus.out_free = CW'(2);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_rd_en) got = 1'b1;
    end
    bus.out_free = CW'(1);
    chk("bp_fetch_seen", 32'(got), 32'd1);
    repeat (10) @(negedge clk);
    chk("bp_one_fetch", 32'(n_rd - rd0), 32'd1);
    chk("bp_op_count", 32'(bus.op_count), 32'd7);
    chk("bp_cmd_left", 32'(bus.cmd_count), 32'd2);
    bus.out_free = CW'(8);
    wait_idle(100, ok);
    chk("bp_drain_idle", 32'(ok), 32'd1);
    chk("bp_drain_op_count", 32'(bus.op_count), 32'd9);

    // Reset while waiting on the engine: command dropped, counters cleared.
    wr0 = n_wr;
    cmd_q.push_back(32'h0000_0009);
    wait_start(ok);
    chk("rstw_start_seen", 32'(ok), 32'd1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_busy", 32'(bus.busy), 32'd0);
    chk("rstw_op_count", 32'(bus.op_count), 32'd0);
    chk("rstw_err_count", 32'(bus.err_count), 32'd0);
    @(posedge clk); #1;
    bus.eng_done_evp = 1'b1;
    @(posedge clk); #1;
    bus.eng_done_evp = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstw_no_write", 32'(n_wr - wr0), 32'd0);

    // Illegal, NOP, NOP, CLR: counters step and then clear together.
    for (int k = 0; k < 4; k++) begin
      if (k == 0) sb_q.push_back(32'hEEEE_0106);
      cmd_q.push_back(clr_cmds[k]);
      wait_idle(100, ok);
      chk($sformatf("clr%0d_idle", k), 32'(ok), 32'd1);
      chk($sformatf("clr%0d_op_count", k), 32'(bus.op_count), 32'(clr_op[k]));
      chk($sformatf("clr%0d_err_count", k), 32'(bus.err_count), 32'(clr_err[k]));
    end

    repeat (5) @(negedge clk);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
